// File: rtl/mult_scheduler_if.sv
// mult_scheduler_if: requester-side and multiplier-side signals of the shared multiplier scheduler.
interface mult_scheduler_if #(parameter int NREQ = 4);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   done;
   logic [4*NREQ-1:0] a_in;
   logic [4*NREQ-1:0] b_in;
   logic [7:0]        prod;
   logic              busy;
   logic              m_start;
   logic [3:0]        m_a;
   logic [3:0]        m_b;
   logic [7:0]        m_p;
   modport slave (input req, a_in, b_in, m_p, output ack, done, prod, busy, m_start, m_a, m_b);
   modport master (output req, a_in, b_in, m_p, input ack, done, prod, busy, m_start, m_a, m_b);
endinterface

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sharing of one 4x4 sequential multiplier between NREQ requesters.
module mult_scheduler #(
   parameter int NREQ        = 4,
   parameter int MULT_CYCLES = 5
) (
   input logic              clk,
   input logic              clr,
   mult_scheduler_if.slave  s
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MULT_CYCLES + 1);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT    = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   g_q, g_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [7:0]      prod_q, prod_d;
   logic            busy_q, busy_d;
   logic            m_start_q, m_start_d;
   logic [3:0]      m_a_q, m_a_d;
   logic [3:0]      m_b_q, m_b_d;
   logic [IW-1:0]   idx, gi;
   logic            found;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      g_d       = g_q;
      ack_d     = '0;
      done_d    = '0;
      prod_d    = prod_q;
      busy_d    = busy_q;
      m_start_d = 1'b0;
      m_a_d     = m_a_q;
      m_b_d     = m_b_q;
      found     = 1'b0;
      gi        = '0;
      idx       = '0;
      // search starts just after the last grant so the previous winner is considered last
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last_q) + k) % NREQ);
         if (!found && s.req[idx]) begin
            found = 1'b1;
            gi    = idx;
         end
      end
      if (state_q == IDLE && found) begin
         g_d       = gi;
         last_d    = gi;
         m_a_d     = s.a_in[{gi, 2'b00} +: 4];
         m_b_d     = s.b_in[{gi, 2'b00} +: 4];
         ack_d     = NREQ'(1) << gi;
         m_start_d = 1'b1;
         busy_d    = 1'b1;
         cnt_d     = CW'(MULT_CYCLES);
         state_d   = WAIT;
      end else if (state_q == WAIT) begin
         cnt_d   = cnt_q - CW'(1);
         state_d = (cnt_q == CW'(1)) ? CAPTURE : WAIT;
      end else if (state_q == CAPTURE) begin
         prod_d  = s.m_p;
         done_d  = NREQ'(1) << g_q;
         busy_d  = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= IW'(NREQ - 1);
         g_q       <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         prod_q    <= '0;
         busy_q    <= 1'b0;
         m_start_q <= 1'b0;
         m_a_q     <= '0;
         m_b_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         g_q       <= g_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         prod_q    <= prod_d;
         busy_q    <= busy_d;
         m_start_q <= m_start_d;
         m_a_q     <= m_a_d;
         m_b_q     <= m_b_d;
      end
   end

   assign s.ack     = ack_q;
   assign s.done    = done_q;
   assign s.prod    = prod_q;
   assign s.busy    = busy_q;
   assign s.m_start = m_start_q;
   assign s.m_a     = m_a_q;
   assign s.m_b     = m_b_q;
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed scoreboard bench for mult_scheduler with a behavioural sequential multiplier.
module tb_mult_scheduler;
   localparam int NREQ = 4;
   localparam int MC   = 5;

   typedef struct {
      int         idx;
      logic [3:0] a;
      logic [3:0] b;
      int         t;
   } op_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic [NREQ-1:0] hold = '0;
   int n_chk = 0;
   int n_fail = 0;
   int n_ack = 0;
   int cyc = 0;
   int mcnt = 0;
   int base;
   logic [7:0] mprod;
   op_t exp_q[$];
   op_t pend_q[$];
   op_t mo;

   mult_scheduler_if #(.NREQ(NREQ)) ifc ();

   mult_scheduler #(.NREQ(NREQ), .MULT_CYCLES(MC)) dut (
      .clk(clk),
      .clr(clr),
      .s  (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // multiplier model: p shows garbage until MC edges after it samples start
   always @(posedge clk) begin
      if (ifc.m_start) begin
         mprod    <= 8'(ifc.m_a) * 8'(ifc.m_b);
         mcnt     <= MC - 1;
         ifc.m_p  <= 8'hAA;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) ifc.m_p <= mprod;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (clr) begin
         chk("ack_done_overlap", 32'(ifc.ack & ifc.done), 0);
         chk("m_start_vs_ack", 32'(ifc.m_start), 32'(|ifc.ack));
         if (ifc.ack != '0) begin
            n_ack++;
            if (exp_q.size() == 0) chk("ack_unexpected", 32'(ifc.ack), 0);
            else begin
               mo = exp_q.pop_front();
               chk("ack_idx", 32'(ifc.ack), 32'(1) << mo.idx);
               mo.t = cyc;
               pend_q.push_back(mo);
            end
            ifc.req = ifc.req & ~(ifc.ack & ~hold);
         end
         if (pend_q.size() > 0) begin
            chk("m_a", 32'(ifc.m_a), 32'(pend_q[0].a));
            chk("m_b", 32'(ifc.m_b), 32'(pend_q[0].b));
         end
         if (ifc.done != '0) begin
            if (pend_q.size() == 0) chk("done_unexpected", 32'(ifc.done), 0);
            else begin
               mo = pend_q.pop_front();
               chk("done_idx", 32'(ifc.done), 32'(1) << mo.idx);
               chk("prod", 32'(ifc.prod), 32'(int'(mo.a) * int'(mo.b)));
               chk("latency", 32'(cyc - mo.t), MC + 1);
            end
         end
         chk("busy", 32'(ifc.busy), 32'(pend_q.size() != 0));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      ifc.a_in[4*i +: 4] = a;
      ifc.b_in[4*i +: 4] = b;
   endtask

   task automatic push(input int i, input logic [3:0] a, input logic [3:0] b);
      op_t o;
      o.idx = i;
      o.a = a;
      o.b = b;
      o.t = 0;
      exp_q.push_back(o);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && pend_q.size() == 0) break;
         step(1);
      end
      chk("drain", 32'(exp_q.size() + pend_q.size()), 0);
   endtask

   task automatic wait_ack(input int target);
      for (int i = 0; i < 60; i++) begin
         if (n_ack >= target) break;
         step(1);
      end
      chk("ack_wait", 32'(n_ack >= target), 1);
   endtask

   task automatic do_reset();
      ifc.req = '0;
      clr = 1'b0;
      #1;
      chk("rst_ack", 32'(ifc.ack), 0);
      chk("rst_done", 32'(ifc.done), 0);
      chk("rst_prod", 32'(ifc.prod), 0);
      chk("rst_busy", 32'(ifc.busy), 0);
      chk("rst_m_start", 32'(ifc.m_start), 0);
      chk("rst_m_a", 32'(ifc.m_a), 0);
      chk("rst_m_b", 32'(ifc.m_b), 0);
      exp_q.delete();
      pend_q.delete();
      hold = '0;
      step(2);
      clr = 1'b1;
      step(1);
   endtask

   initial begin
      ifc.req = '0;
      ifc.a_in = '0;
      ifc.b_in = '0;
      step(2);
      do_reset();
      // single operation
      set_op(0, 9, 7);
      push(0, 9, 7);
      ifc.req = 4'b0001;
      wait_idle();
      // all requesters at once, from a fresh pointer
      do_reset();
      set_op(0, 1, 2);
      set_op(1, 3, 4);
      set_op(2, 5, 6);
      set_op(3, 15, 15);
      push(0, 1, 2);
      push(1, 3, 4);
      push(2, 5, 6);
      push(3, 15, 15);
      ifc.req = 4'b1111;
      wait_idle();
      // zero operand
      set_op(1, 0, 13);
      push(1, 0, 13);
      ifc.req = 4'b0010;
      wait_idle();
      // operands changed after grant must not matter
      set_op(2, 6, 7);
      push(2, 6, 7);
      base = n_ack;
      ifc.req = 4'b0100;
      wait_ack(base + 1);
      set_op(2, 3, 1);
      wait_idle();
      // withdrawn request while busy
      set_op(0, 5, 5);
      push(0, 5, 5);
      base = n_ack;
      ifc.req[0] = 1'b1;
      wait_ack(base + 1);
      step(1);
      ifc.req[1] = 1'b1;
      step(2);
      ifc.req[1] = 1'b0;
      wait_idle();
      step(8);
      chk("withdraw_acks", 32'(n_ack), 32'(base + 1));
      // fairness: requester 0 held, requester 2 asserted once
      do_reset();
      set_op(0, 2, 3);
      set_op(2, 4, 5);
      push(0, 2, 3);
      push(2, 4, 5);
      push(0, 2, 3);
      push(0, 2, 3);
      base = n_ack;
      hold = 4'b0001;
      ifc.req = 4'b0101;
      wait_ack(base + 4);
      ifc.req[0] = 1'b0;
      hold = '0;
      wait_idle();
      // reset in the middle of WAIT discards the operation
      set_op(0, 11, 12);
      push(0, 11, 12);
      base = n_ack;
      ifc.req = 4'b0001;
      wait_ack(base + 1);
      step(1);
      do_reset();
      step(10);
      set_op(3, 10, 10);
      push(3, 10, 10);
      ifc.req = 4'b1000;
      wait_idle();
      step(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Round-robin scheduler that shares one seq_multiplier (4x4 -> 8-bit) between NREQ requesters.
- Accepts one request at a time and drives the multiplier's start/a/b inputs.
- Waits a fixed MULT_CYCLES latency, captures the 8-bit product, then returns it to the granted requester with a done pulse.
- Sits between requester logic (e.g. switch/button front-ends) and the multiplier/display path.

Parameters:
NREQ, 4, number of requesters (2..8)
MULT_CYCLES, 5, clock edges from the edge at which the multiplier samples start=1 until its p output is valid (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  reset, asynchronous, active-low; clears all state immediately
req  in  NREQ  request per requester; level, held until ack
a_in  in  4*NREQ  packed operand A, requester i at [4i+3:4i]
b_in  in  4*NREQ  packed operand B, requester i at [4i+3:4i]
ack  out  NREQ  one-cycle pulse, operands of requester i captured
done  out  NREQ  one-cycle pulse, prod valid for requester i
prod  out  8  last captured product, held until next capture
busy  out  1  high whenever an operation is in flight
m_start  out  1  to multiplier start, one-cycle pulse
m_a  out  4  to multiplier a, stable from grant through capture
m_b  out  4  to multiplier b, stable from grant through capture
m_p  in  8  from multiplier p

Behaviour:
- All outputs are registered.
- Reset (clr=0, async): state IDLE; ack, done, prod, busy, m_start, m_a, m_b = 0; counter = 0; rr pointer last = NREQ-1, so requester 0 has first priority.
- States: IDLE, WAIT, CAPTURE.
- IDLE, req != 0 at edge E0:
  - Choose the first asserted index in order last+1, last+2, ... (mod NREQ); store it in g.
  - Load m_a = a_in[g], m_b = b_in[g].
  - Set ack[g] = 1, m_start = 1, busy = 1, cnt = MULT_CYCLES, last = g. Go to WAIT.
- IDLE, req == 0: remain; outputs unchanged except pulses, which are 0.
- WAIT:
  - ack and m_start drop at the edge after E0; each is exactly one cycle.
  - cnt decrements every edge; when cnt == 1 at an edge, go to CAPTURE.
  - m_p is sampled on the edge after that.
- CAPTURE edge (E0 + MULT_CYCLES + 1): prod = m_p, done[g] = 1, busy = 0, go to IDLE.
- done drops on the next edge. That same edge may already grant a new request, so done and the next ack never overlap.
- Throughput: one operation per MULT_CYCLES+2 cycles. Grant-to-done latency: MULT_CYCLES+1 edges.
- req changes during WAIT/CAPTURE are ignored; the next arbitration uses req as sampled in IDLE.
- Requester protocol:
  - Drop req on the cycle ack is seen, or a second operation is issued for it.
  - Dropping req before ack withdraws the request; no ack or done follows.
- Operands are captured only at the grant edge; a_in/b_in changes afterwards do not affect the result.
- ack and done are one-hot or zero, and only ever asserted for index g.
- m_a/m_b hold their values after CAPTURE until the next grant; prod holds until the next CAPTURE.
- Fairness: a continuously asserted requester cannot be granted twice while another requester is waiting.
- Reset mid-operation: the in-flight operation is discarded and done is never issued for it. After clr releases, behave as after power-up.

Test Plan:
- Single op, MULT_CYCLES=5: req=0001, a_in[3:0]=9, b_in[3:0]=7 -> ack=0001 and m_start=1 for one cycle after grant edge, m_a=9, m_b=7; done=0001 six edges after grant with prod=63; busy high in between.
- All requesters simultaneously, operands (1,2),(3,4),(5,6),(15,15), each dropping req on ack -> grants in order 0,1,2,3; prods 2,12,30,225, each done on its own index; no overlap of ack with done.
- Fairness: req0 held permanently, req2 asserted once and held until ack -> order 0,2,0,0,...; req2 granted on the second arbitration.
- Boundaries: 15*15 -> prod=225 (8'hE1); 0*13 -> prod=0; a_in changed during WAIT -> prod still uses captured operands.
- Withdraw: req1 asserted while busy, dropped before IDLE -> no ack[1] and no done[1], scheduler returns to IDLE.
- Reset mid-WAIT: pull clr low 2 cycles after grant -> all outputs 0 immediately, no done pulse; after release, req=1000 is granted and completes normally.
